// File: rtl/db_strobe_cmp.sv
// Double-buffered strobe/compare register for one receive-side tester pin.
// Optional fail counter built only when FAIL_COUNT_EN is defined.
module db_strobe_cmp #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CYCLE,
    input  logic             LOAD,
    input  logic             TRANSFER,
    input  logic [1:0]       CM,
    input  logic             EXP,
    input  logic             MASK,
    input  logic             DUT_IN,
    input  logic             CLR,
    output logic             RESULT_VALID,
    output logic             PASS,
    output logic             FAIL,
    output logic             CAPTURED,
    output logic             STICKY_FAIL,
    output logic [CNT_W-1:0] FAIL_CNT
);

    typedef enum logic {IDLE, WINDOW} state_t;

    state_t state_q, state_d;
    logic   dut_m, dut_s, cyc_q;
    logic   lead, trail;
    logic   buf_exp, buf_mask, act_exp, act_mask;
    logic   win_exp, win_mask, win_err;
    logic   cur_mis, win_mis;
    logic   win_load, strobe, strobe_fail;
    logic   stg_vld, stg_fail, stg_cap;
    logic   fail_evt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            dut_m <= 1'b0;
            dut_s <= 1'b0;
            cyc_q <= 1'b0;
        end else begin
            dut_m <= DUT_IN;
            dut_s <= dut_m;
            cyc_q <= CYCLE;
        end
    end

    assign lead  = CYCLE & ~cyc_q;
    assign trail = ~CYCLE & cyc_q;

    // LOAD wins over TRANSFER; a reset compare is fully masked.
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_exp  <= 1'b0;
            buf_mask <= 1'b1;
            act_exp  <= 1'b0;
            act_mask <= 1'b1;
        end else if (LOAD) begin
            buf_exp  <= EXP;
            buf_mask <= MASK;
        end else if (TRANSFER) begin
            act_exp  <= buf_exp;
            act_mask <= buf_mask;
        end
    end

    assign cur_mis = (dut_s != act_exp) & ~act_mask;
    assign win_mis = (dut_s != win_exp) & ~win_mask;

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        win_load    = 1'b0;
        strobe      = 1'b0;
        strobe_fail = 1'b0;
        case (state_q)
            IDLE: begin
                case (CM)
                    2'b00: if (lead) begin
                        strobe      = 1'b1;
                        strobe_fail = cur_mis;
                    end
                    2'b01: if (trail) begin
                        strobe      = 1'b1;
                        strobe_fail = cur_mis;
                    end
                    2'b10: if (lead) begin
                        win_load = 1'b1;
                        state_d  = WINDOW;
                    end
                    default: ;
                endcase
            end
            WINDOW: begin
                // The trailing sample itself is folded into the verdict.
                if (trail) begin
                    strobe      = 1'b1;
                    strobe_fail = win_err | win_mis;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Window runs on its own snapshot so TRANSFER cannot disturb it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            win_exp  <= 1'b0;
            win_mask <= 1'b1;
            win_err  <= 1'b0;
        end else if (win_load) begin
            win_exp  <= act_exp;
            win_mask <= act_mask;
            win_err  <= cur_mis;
        end else if (state_q == WINDOW) begin
            win_err  <= win_err | win_mis;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stg_vld      <= 1'b0;
            stg_fail     <= 1'b0;
            stg_cap      <= 1'b0;
            RESULT_VALID <= 1'b0;
            PASS         <= 1'b0;
            FAIL         <= 1'b0;
            CAPTURED     <= 1'b0;
        end else begin
            stg_vld      <= strobe;
            RESULT_VALID <= stg_vld;
            if (strobe) begin
                stg_fail <= strobe_fail;
                stg_cap  <= dut_s;
            end
            if (stg_vld) begin
                PASS     <= ~stg_fail;
                FAIL     <= stg_fail;
                CAPTURED <= stg_cap;
            end
        end
    end

    assign fail_evt = stg_vld & stg_fail;

    // CLR is applied before a coincident fail is recorded.
    always_ff @(posedge CLK) begin
        if (RST) STICKY_FAIL <= 1'b0;
        else     STICKY_FAIL <= (STICKY_FAIL & ~CLR) | fail_evt;
    end

`ifdef FAIL_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_base;

    assign cnt_base = CLR ? '0 : cnt_q;

    always_ff @(posedge CLK) begin
        if (RST)                          cnt_q <= '0;
        else if (fail_evt && cnt_base != '1) cnt_q <= cnt_base + CNT_W'(1);
        else                              cnt_q <= cnt_base;
    end

    assign FAIL_CNT = cnt_q;
`else
    assign FAIL_CNT = '0;
`endif

endmodule
